// File: rtl/snn_noc_pkg.sv
// snn_noc_pkg
// Shared types and constants for the spike network interface / NoC edge.
//   state_e      : dispatcher FSM encoding (IDLE, SELECT, EMIT)
//   PACKET_WIDTH : {origin, destination} width for the standard 12-bit address
//   ORIGIN_LSB / DEST_LSB : field offsets inside a packet
//   sat_inc8     : saturating 8-bit increment used by event counters
package snn_noc_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int PACKET_WIDTH   = 2 * ADDR_WIDTH_DEF;
  localparam int ORIGIN_LSB     = ADDR_WIDTH_DEF;
  localparam int DEST_LSB       = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lowest_set_bit_finder.sv
// lowest_set_bit_finder
// Priority encoder: reports the index of the least-significant set bit.
//   vec_i   : input bit vector
//   index_o : index of lowest set bit (0 when nothing set)
//   found_o : at least one bit of vec_i is set
module lowest_set_bit_finder #(
  parameter int WIDTH = 10,
  parameter int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] index_o,
  output logic             found_o
);

  // Scan from the top so the last hit (lowest index) wins.
  always_comb begin
    index_o = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        index_o = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_packet_dispatcher.sv
// spike_packet_dispatcher
// Collects per-neuron spike flags over a timestep, snapshots them on clear,
// then walks a CSR downstream table and emits one {origin, destination}
// packet per connection on a valid/ready handshake.
//   CLK, RESET      : clock, synchronous active-high reset
//   clear           : timestep boundary pulse
//   spikes          : per-neuron spike flags (bit i = neuron i)
//   load_config     : captures the three *_initialization buses (IDLE only)
//   packet/_valid/_ready : output packet stream
//   busy            : FSM not in IDLE
//   overrun_count   : saturating count of clears seen while busy
module spike_packet_dispatcher
  import snn_noc_pkg::*;
#(
  parameter int NUM_NEURONS     = 10,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_CONNECTIONS = 30,
  parameter int PTR_WIDTH       = 5
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   clear,
  input  logic [NUM_NEURONS-1:0]                 spikes,
  input  logic                                   load_config,
  input  logic [NUM_NEURONS*ADDR_WIDTH-1:0]      neuron_addresses_initialization,
  input  logic [(NUM_NEURONS+1)*PTR_WIDTH-1:0]   connection_pointer_initialization,
  input  logic [MAX_CONNECTIONS*ADDR_WIDTH-1:0]  downstream_connections_initialization,
  output logic [2*ADDR_WIDTH-1:0]                packet,
  output logic                                   packet_valid,
  input  logic                                   packet_ready,
  output logic                                   busy,
  output logic [7:0]                             overrun_count
);

  localparam int IDX_W     = $clog2(NUM_NEURONS + 1);
  // Destination table is sized to the full pointer range so any pointer value
  // is a legal index; entries at or above MAX_CONNECTIONS stay zero.
  localparam int DEST_DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH-1:0] MAX_C   = PTR_WIDTH'(MAX_CONNECTIONS);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);

  // Config tables
  logic [ADDR_WIDTH-1:0] addr_q [NUM_NEURONS];
  logic [PTR_WIDTH-1:0]  ptr_q  [NUM_NEURONS+1];
  logic [ADDR_WIDTH-1:0] dest_q [DEST_DEPTH];

  // Dispatch state
  state_e                state_q;
  logic [NUM_NEURONS-1:0] pending_q, active_q;
  logic [IDX_W-1:0]      n_q;
  logic [PTR_WIDTH-1:0]  cur_q, end_q;
  logic [2*ADDR_WIDTH-1:0] packet_q;
  logic                  valid_q;
  logic [7:0]            overrun_q;

  logic [IDX_W-1:0]      sel_idx, sel_idx_p1;
  logic                  sel_found;
  logic [PTR_WIDTH-1:0]  sel_cur, sel_end, cur_nxt;
  logic [NUM_NEURONS-1:0] snapshot;

  lowest_set_bit_finder #(
    .WIDTH (NUM_NEURONS),
    .IDX_W (IDX_W)
  ) u_lsb (
    .vec_i   (active_q),
    .index_o (sel_idx),
    .found_o (sel_found)
  );

  assign sel_idx_p1 = sel_idx + IDX_ONE;
  assign sel_cur    = ptr_q[sel_idx];
  assign sel_end    = ptr_q[sel_idx_p1];
  assign cur_nxt    = cur_q + PTR_ONE;
  // A spike coincident with clear belongs to the ending timestep.
  assign snapshot   = pending_q | spikes;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      pending_q <= '0;
      active_q  <= '0;
      n_q       <= '0;
      cur_q     <= '0;
      end_q     <= '0;
      packet_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++)     addr_q[i] <= '0;
      for (int i = 0; i <= NUM_NEURONS; i++)    ptr_q[i]  <= '0;
      for (int k = 0; k < DEST_DEPTH; k++)      dest_q[k] <= '0;
    end else begin
      pending_q <= pending_q | spikes;
      if (clear && (state_q != IDLE))
        overrun_q <= sat_inc8(overrun_q);

      case (state_q)
        IDLE: begin
          packet_q <= '0;
          valid_q  <= 1'b0;
          if (load_config) begin
            for (int i = 0; i < NUM_NEURONS; i++)
              addr_q[i] <= neuron_addresses_initialization[i*ADDR_WIDTH +: ADDR_WIDTH];
            for (int i = 0; i <= NUM_NEURONS; i++)
              ptr_q[i] <= connection_pointer_initialization[i*PTR_WIDTH +: PTR_WIDTH];
            for (int k = 0; k < MAX_CONNECTIONS; k++)
              dest_q[k] <= downstream_connections_initialization[k*ADDR_WIDTH +: ADDR_WIDTH];
          end
          if (clear) begin
            active_q  <= snapshot;
            pending_q <= '0;
            if (snapshot != '0) state_q <= SELECT;
          end
        end

        SELECT: begin
          if (!sel_found) begin
            state_q <= IDLE;
          end else if ((sel_end <= sel_cur) || (sel_cur >= MAX_C)) begin
            // Empty or out-of-table row: retire the neuron, one cycle spent.
            active_q[sel_idx] <= 1'b0;
          end else begin
            n_q      <= sel_idx;
            cur_q    <= sel_cur;
            end_q    <= sel_end;
            packet_q <= {addr_q[sel_idx], dest_q[sel_cur]};
            valid_q  <= 1'b1;
            state_q  <= EMIT;
          end
        end

        EMIT: begin
          if (packet_ready) begin
            cur_q <= cur_nxt;
            if ((cur_nxt >= end_q) || (cur_nxt >= MAX_C)) begin
              active_q[n_q] <= 1'b0;
              valid_q       <= 1'b0;
              state_q       <= SELECT;
            end else begin
              packet_q <= {addr_q[n_q], dest_q[cur_nxt]};
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign packet        = packet_q;
  assign packet_valid  = valid_q;
  assign busy          = (state_q != IDLE);
  assign overrun_count = overrun_q;

endmodule
